pcie_sram_port_arbiter: RTL and testbench
=========================================

PCIE_SRAM_PORT_ARBITER -- requirements
Module: pcie_sram_port_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 256, SRAM word width in bits.
REQ-002 Parameter: ADDR_WIDTH, 10, SRAM word address width.
REQ-003 Parameter: STARVE_LIMIT, 4, maximum consecutive write grants while a read is pending; legal range 1..15.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_req  in  1  write requester (message receiver) asks for an SRAM write this cycle.
REQ-007 wr_addr, wr_data  in  ADDR_WIDTH, DATA_WIDTH  write address and data, valid while wr_req=1.
REQ-008 wr_gnt  out  1  write is performed this cycle.
REQ-009 rd_req, rd_addr  in  1, ADDR_WIDTH  read requester (AXI-to-SRAM reader) asks for a read of rd_addr.
REQ-010 rd_gnt  out  1  read is issued to the SRAM this cycle.
REQ-011 rd_rvalid, rd_rdata  out  1, DATA_WIDTH  read data return, one cycle after rd_gnt.
REQ-012 sram_cs, sram_we, sram_addr, sram_wdata  out  1, 1, ADDR_WIDTH, DATA_WIDTH  single-port SRAM command.
REQ-013 sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read command.

Function
REQ-014 The arbiter SHALL time-share one single-port SRAM between the write and read requesters, with at most one access per cycle.
REQ-015 A transfer SHALL complete in the cycle in which req=1 and gnt=1; a requester SHALL hold its req, addr and data stable until granted.
REQ-016 wr_gnt and rd_gnt SHALL be combinational from req inputs and state, mutually exclusive, and never asserted without the matching req.
REQ-017 FSM states: WR_PRI (reset state) and RD_PRI; 4-bit counter starve_cnt counts consecutive write grants issued while rd_req=1.
REQ-018 In WR_PRI: wr_req=1 -> grant write; if rd_req=1, starve_cnt+1, and when the new value equals STARVE_LIMIT go to RD_PRI; if rd_req=0, starve_cnt cleared.
REQ-019 In WR_PRI with wr_req=0 and rd_req=1 -> grant read, starve_cnt cleared, stay in WR_PRI.
REQ-020 In RD_PRI: rd_req=1 -> grant read, clear starve_cnt, return to WR_PRI; rd_req=0 -> grant write if wr_req=1, clear starve_cnt, return to WR_PRI.
REQ-021 No requests -> no grant, sram_cs=0, state and starve_cnt held.
REQ-022 On a write grant: sram_cs=1, sram_we=1, sram_addr=wr_addr, sram_wdata=wr_data.
REQ-023 On a read grant: sram_cs=1, sram_we=0, sram_addr=rd_addr; sram_wdata SHALL be driven 0.
REQ-024 rd_rvalid SHALL be a register set the cycle after rd_gnt=1; rd_rdata SHALL equal sram_rdata while rd_rvalid=1 and 0 otherwise.
REQ-025 Back-to-back read grants SHALL yield rd_rvalid on consecutive cycles with no bubble.
REQ-026 Same-address read and write pending together: grant order follows REQ-018..020; no forwarding is performed; the read returns SRAM contents at its grant cycle.

Reset
REQ-027 While rst=1: wr_gnt=0, rd_gnt=0, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0, rd_rvalid=0, rd_rdata=0, state=WR_PRI, starve_cnt=0.
REQ-028 A read granted in the cycle before rst rises SHALL NOT produce rd_rvalid; reset wins.
REQ-029 The first grant after rst falls SHALL follow WR_PRI rules.

Configuration
REQ-030 Macro PCIE_SRAM_ARB_STATS_EN defined: extra outputs wr_gnt_count[15:0], rd_gnt_count[15:0], starve_evt_count[7:0]; these count write grants, read grants and WR_PRI->RD_PRI transitions, saturate at all-ones, and reset to 0.
REQ-031 Macro PCIE_SRAM_ARB_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-032 wr_req=1 only, 3 cycles, addrs 0x010..0x012 -> wr_gnt=1 each cycle, sram_we=1, data written to the correct addresses, rd_rvalid=0.
REQ-033 rd_req=1 only, addr 0x010 after REQ-032 -> rd_gnt=1 at cycle N, rd_rvalid=1 at N+1, rd_rdata equals the data written to 0x010.
REQ-034 wr_req and rd_req held 1 continuously, STARVE_LIMIT=4 -> grant pattern W,W,W,W,R repeating; starve_evt_count increments once per pattern (stats build).
REQ-035 Both requesting in RD_PRI, rd_req drops that cycle -> write granted, state returns to WR_PRI, starve_cnt=0.
REQ-036 rst raised the cycle after a read grant -> rd_rvalid stays 0, all outputs 0 during reset, first post-reset contention grants write.
REQ-037 Build without PCIE_SRAM_ARB_STATS_EN, rerun REQ-034 -> identical grant sequence; stats ports absent from the netlist.

Source files
------------

// File: rtl/pcie_sram_port_arbiter.sv
// Write/read arbiter sharing one single-port SRAM, with an anti-starvation limit on writes.
// Optional grant statistics outputs are built when PCIE_SRAM_ARB_STATS_EN is defined.
module pcie_sram_port_arbiter #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef PCIE_SRAM_ARB_STATS_EN
  ,
  output logic [15:0]           wr_gnt_count,
  output logic [15:0]           rd_gnt_count,
  output logic [7:0]            starve_evt_count
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    WR_PRI = 1'b0,
    RD_PRI = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       rd_vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WR_PRI;
      starve_cnt <= '0;
      rd_vld_p0  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      rd_vld_p0  <= rd_gnt;
    end
  end

  // Count writes that overtake a waiting read; hitting the limit hands priority to the read.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    case (state)
      WR_PRI: begin
        if (wr_req) begin
          if (rd_req) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
            if (starve_cnt_nxt == LIMIT) state_nxt = RD_PRI;
          end else begin
            starve_cnt_nxt = '0;
          end
        end else if (rd_req) begin
          starve_cnt_nxt = '0;
        end
      end
      RD_PRI: begin
        if (rd_req || wr_req) begin
          state_nxt      = WR_PRI;
          starve_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt      = WR_PRI;
        starve_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!rst) begin
      case (state)
        WR_PRI: begin
          if (wr_req)      wr_gnt = 1'b1;
          else if (rd_req) rd_gnt = 1'b1;
        end
        RD_PRI: begin
          if (rd_req)      rd_gnt = 1'b1;
          else if (wr_req) wr_gnt = 1'b1;
        end
        default: begin
          wr_gnt = 1'b0;
          rd_gnt = 1'b0;
        end
      endcase
    end
    sram_cs    = wr_gnt | rd_gnt;
    sram_we    = wr_gnt;
    sram_addr  = wr_gnt ? wr_addr : (rd_gnt ? rd_addr : '0);
    sram_wdata = wr_gnt ? wr_data : '0;
  end

  // Return stage: a read issued just before reset must not surface while reset is held.
  assign rd_rvalid = rd_vld_p0 & ~rst;
  assign rd_rdata  = rd_rvalid ? sram_rdata : '0;

`ifdef PCIE_SRAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_gnt_count     <= '0;
      rd_gnt_count     <= '0;
      starve_evt_count <= '0;
    end else begin
      if (wr_gnt) wr_gnt_count <= sat_inc16(wr_gnt_count);
      if (rd_gnt) rd_gnt_count <= sat_inc16(rd_gnt_count);
      if (state == WR_PRI && state_nxt == RD_PRI)
        starve_evt_count <= sat_inc8(starve_evt_count);
    end
  end
`endif

endmodule

// File: tb/tb_pcie_sram_port_arbiter.sv
// Scoreboard bench for pcie_sram_port_arbiter: behavioural SRAM, queued read-data expectations.
// Stats checks are compiled in when PCIE_SRAM_ARB_STATS_EN is defined.
module tb_pcie_sram_port_arbiter;
  localparam int DW = 256;
  localparam int AW = 10;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd_gnt, rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
`ifdef PCIE_SRAM_ARB_STATS_EN
  logic [15:0]   wr_gnt_count, rd_gnt_count;
  logic [7:0]    starve_evt_count;
`endif

  int total = 0;
  int bad = 0;
  int exp_wcnt = 0, exp_rcnt = 0, exp_evt = 0;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] rdq [$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  pcie_sram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef PCIE_SRAM_ARB_STATS_EN
    , .wr_gnt_count(wr_gnt_count), .rd_gnt_count(rd_gnt_count),
    .starve_evt_count(starve_evt_count)
`endif
  );

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  always @(negedge clk) begin
    total++;
    if (rd_rvalid === 1'b1) begin
      if (rdq.size() == 0) begin
        bad++;
        $display("FAIL rvalid_unexpected: got rd_rvalid=1 want no pending read");
      end else begin
        logic [DW-1:0] e;
        e = rdq.pop_front();
        if (rd_rdata !== e) begin
          bad++;
          $display("FAIL rd_rdata: got %0h want %0h", rd_rdata, e);
        end
      end
    end else if (rd_rdata !== '0) begin
      bad++;
      $display("FAIL rd_rdata_idle: got %0h want 0", rd_rdata);
    end
  end

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] ra);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 10'h155, rnd(), 1'b1, 10'h0AA);
    @(negedge clk);
    total++; if (wr_gnt !== 1'b0) begin bad++; $display("FAIL rst_wr_gnt: got %b want 0", wr_gnt); end
    total++; if (rd_gnt !== 1'b0) begin bad++; $display("FAIL rst_rd_gnt: got %b want 0", rd_gnt); end
    total++; if (sram_cs !== 1'b0) begin bad++; $display("FAIL rst_sram_cs: got %b want 0", sram_cs); end
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rst_sram_we: got %b want 0", sram_we); end
    total++; if (sram_addr !== '0) begin bad++; $display("FAIL rst_sram_addr: got %0h want 0", sram_addr); end
    total++; if (sram_wdata !== '0) begin bad++; $display("FAIL rst_sram_wdata: got %0h want 0", sram_wdata); end
    total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", rd_rvalid); end
    next_cycle();
    @(negedge clk);
`ifdef PCIE_SRAM_ARB_STATS_EN
    total++; if (wr_gnt_count !== 16'd0 || rd_gnt_count !== 16'd0 || starve_evt_count !== 8'd0) begin
      bad++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", wr_gnt_count, rd_gnt_count, starve_evt_count);
    end
`endif
    next_cycle();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    total++; if (sram_cs !== 1'b0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst: got cs=%b wg=%b rg=%b want 0", sram_cs, wr_gnt, rd_gnt);
    end
    next_cycle();
  endtask

  task automatic test_write_only();
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    for (int i = 0; i < 3; i++) begin
      wa = 10'h010 + AW'(i);
      wd = rnd();
      drive(1'b1, wa, wd, 1'b0, '0);
      ref_mem[int'(wa)] = wd; exp_wcnt++;
      @(negedge clk);
      total++; if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin bad++; $display("FAIL wr_only_gnt: got wg=%b rg=%b want 1/0", wr_gnt, rd_gnt); end
      total++; if (sram_we !== 1'b1 || sram_cs !== 1'b1) begin bad++; $display("FAIL wr_only_we: got cs=%b we=%b want 1/1", sram_cs, sram_we); end
      total++; if (sram_addr !== wa) begin bad++; $display("FAIL wr_only_addr: got %0h want %0h", sram_addr, wa); end
      total++; if (sram_wdata !== wd) begin bad++; $display("FAIL wr_only_wdata: got %0h want %0h", sram_wdata, wd); end
      total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL wr_only_rvalid: got %b want 0", rd_rvalid); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back_read();
    logic [AW-1:0] ra;
    for (int i = 0; i < 3; i++) begin
      ra = 10'h010 + AW'(i);
      drive(1'b0, '0, '0, 1'b1, ra);
      rdq.push_back(ref_mem[int'(ra)]); exp_rcnt++;
      @(negedge clk);
      total++; if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0) begin bad++; $display("FAIL rd_gnt: got rg=%b wg=%b want 1/0", rd_gnt, wr_gnt); end
      total++; if (sram_we !== 1'b0 || sram_addr !== ra) begin bad++; $display("FAIL rd_cmd: got we=%b addr=%0h want 0/%0h", sram_we, sram_addr, ra); end
      total++; if (sram_wdata !== '0) begin bad++; $display("FAIL rd_wdata: got %0h want 0", sram_wdata); end
      if (i > 0) begin
        total++; if (rd_rvalid !== 1'b1) begin bad++; $display("FAIL rd_bubble: got rd_rvalid=%b want 1", rd_rvalid); end
      end
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    total++; if (rd_rvalid !== 1'b1) begin bad++; $display("FAIL rd_last_rvalid: got %b want 1", rd_rvalid); end
    total++; if (sram_cs !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin bad++; $display("FAIL idle_cs: got cs=%b want 0", sram_cs); end
    next_cycle();
    @(negedge clk);
    total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop: got %b want 0", rd_rvalid); end
    next_cycle();
  endtask

  // Both requesters held: writes overtake the read LIMIT times, then the read goes.
  task automatic contend(input int cycles, input string tag);
    int run;
    logic exp_w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    run = 0;
    wa = 10'h010;
    wd = rnd();
    for (int i = 0; i < cycles; i++) begin
      exp_w = (run < LIMIT);
      drive(1'b1, wa, wd, 1'b1, 10'h010);
      if (exp_w) begin
        ref_mem[int'(wa)] = wd; exp_wcnt++; run++;
        if (run == LIMIT) exp_evt++;
      end else begin
        rdq.push_back(ref_mem[32'h010]); exp_rcnt++; run = 0;
      end
      @(negedge clk);
      total++; if (wr_gnt !== exp_w || rd_gnt !== !exp_w) begin
        bad++; $display("FAIL %s_pattern[%0d]: got wg=%b rg=%b want wg=%b", tag, i, wr_gnt, rd_gnt, exp_w);
      end
      next_cycle();
      if (exp_w) begin
        wa = (wa == 10'h013) ? 10'h010 : wa + 10'd1;
        wd = rnd();
      end
    end
  endtask

  task automatic test_starvation();
    contend(15, "starve");
    drive(1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
`ifdef PCIE_SRAM_ARB_STATS_EN
    total++; if (starve_evt_count !== 8'(exp_evt)) begin bad++; $display("FAIL starve_evt: got %0d want %0d", starve_evt_count, exp_evt); end
    total++; if (wr_gnt_count !== 16'(exp_wcnt) || rd_gnt_count !== 16'(exp_rcnt)) begin
      bad++; $display("FAIL gnt_counts: got %0d/%0d want %0d/%0d", wr_gnt_count, rd_gnt_count, exp_wcnt, exp_rcnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_rd_drop();
    logic [DW-1:0] wd;
    contend(4, "drop_pre");
    wd = rnd();
    drive(1'b1, 10'h030, wd, 1'b0, '0);
    ref_mem[32'h030] = wd; exp_wcnt++;
    @(negedge clk);
    total++; if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin bad++; $display("FAIL rdpri_drop: got wg=%b rg=%b want 1/0", wr_gnt, rd_gnt); end
    next_cycle();
    contend(5, "drop_post");
  endtask

  task automatic test_reset_after_read();
    drive(1'b0, '0, '0, 1'b1, 10'h011);
    exp_rcnt++;
    @(negedge clk);
    total++; if (rd_gnt !== 1'b1) begin bad++; $display("FAIL pre_rst_rd_gnt: got %b want 1", rd_gnt); end
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 10'h012, rnd(), 1'b1, 10'h011);
    @(negedge clk);
    total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL rst_kills_rvalid: got %b want 0", rd_rvalid); end
    total++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || sram_cs !== 1'b0) begin
      bad++; $display("FAIL rst_outputs: got wg=%b rg=%b cs=%b want 0", wr_gnt, rd_gnt, sram_cs);
    end
    next_cycle();
    exp_wcnt = 0; exp_rcnt = 0; exp_evt = 0;
    rst = 1'b0;
    contend(4, "rst_pre");
    rst = 1'b1;
    exp_wcnt = 0; exp_rcnt = 0; exp_evt = 0;
    drive(1'b1, 10'h010, rnd(), 1'b1, 10'h010);
    @(negedge clk);
    total++; if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin bad++; $display("FAIL rst_rdpri_gnt: got wg=%b rg=%b want 0", wr_gnt, rd_gnt); end
    next_cycle();
    rst = 1'b0;
    contend(5, "post_rst");
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0);
    test_reset();
    test_write_only();
    test_back_to_back_read();
    test_starvation();
    test_rd_drop();
    test_reset_after_read();
    drive(1'b0, '0, '0, 1'b0, '0);
    next_cycle();
    next_cycle();
    total++;
    if (rdq.size() != 0) begin
      bad++; $display("FAIL rdq_drain: got %0d pending reads want 0", rdq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
